spi_reg_bridge: RTL and testbench



---
 rtl/spi_reg_bridge.sv | 196 +++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns CMD/ADDR/DATA frames into single-cycle register-bus accesses.
// All SPI pins are oversampled in clk; clk must run at least 8x sck.
`default_nettype none

module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              sck,
  input  logic              ssn,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              cs,
  output logic              rw,
  output logic [7:0]        addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              frm_err
);

  localparam int FRAME_BITS = 16 + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(15);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_BITS - 1);
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4,
    SKIP  = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ssn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   armed;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] rd_shift;
  logic              is_read;

  logic       sck_rise;
  logic       sck_fall;
  logic       ssn_fall;
  logic       ssn_rise;
  logic       mosi_bit;
  logic [7:0] next_byte;
  logic [DATA_W-1:0] next_word;

  // ssn flops clear to 0, so a select held low across reset release never looks like a fresh fall.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      sck_sync  <= '0;
      ssn_sync  <= '0;
      mosi_sync <= '0;
      armed     <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], ssn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      armed     <= armed | ssn_sync[SYNC_STAGES-2];
      miso_oe   <= armed & ~ssn_sync[SYNC_STAGES-2];
    end
  end

  assign sck_rise  =  sck_sync[SYNC_STAGES-2] & ~sck_sync[SYNC_STAGES-1];
  assign sck_fall  = ~sck_sync[SYNC_STAGES-2] &  sck_sync[SYNC_STAGES-1];
  assign ssn_fall  = ~ssn_sync[SYNC_STAGES-2] &  ssn_sync[SYNC_STAGES-1];
  assign ssn_rise  =  ssn_sync[SYNC_STAGES-2] & ~ssn_sync[SYNC_STAGES-1];
  // mosi is stable for half an sck period, so the one-clk-later stage is safe to sample.
  assign mosi_bit  = mosi_sync[SYNC_STAGES-1];
  assign next_byte = {shift_in[6:0], mosi_bit};
  assign next_word = {shift_in[DATA_W-2:0], mosi_bit};

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift_in <= '0;
      rd_shift <= '0;
      is_read  <= 1'b0;
      miso     <= 1'b0;
      cs       <= 1'b0;
      rw       <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      frm_err  <= 1'b0;
    end else begin
      cs      <= 1'b0;
      frm_err <= 1'b0;
      if (cs && !rw) begin
        rd_shift <= rdata;
      end

      if (ssn_rise) begin
        if (state == CMD || state == ADDR || state == WDATA || state == RDATA) begin
          frm_err <= 1'b1;
        end
        state   <= IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ssn_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end

          CMD: begin
            if (sck_rise) begin
              shift_in <= next_word;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_CMD) begin
                if (next_byte == CMD_WRITE || next_byte == CMD_READ) begin
                  state   <= ADDR;
                  is_read <= next_byte[0];
                end else begin
                  state   <= SKIP;
                  frm_err <= 1'b1;
                end
              end
            end
          end

          ADDR: begin
            if (sck_rise) begin
              shift_in <= next_word;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_ADDR) begin
                addr <= next_byte;
                if (is_read) begin
                  state <= RDATA;
                  cs    <= 1'b1;
                  rw    <= 1'b0;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end

          WDATA: begin
            if (sck_rise) begin
              shift_in <= next_word;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_DATA) begin
                wdata <= next_word;
                cs    <= 1'b1;
                rw    <= 1'b1;
                state <= SKIP;
              end
            end
          end

          RDATA: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_DATA) begin
                state <= SKIP;
                miso  <= 1'b0;
              end
            end else if (sck_fall) begin
              miso     <= rd_shift[DATA_W-1];
              rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
            end
          end

          SKIP: begin
            miso <= 1'b0;
          end

          default: begin
            state <= IDLE;
            miso  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
// Directed-frame bench for spi_reg_bridge: a frame-level model predicts bus accesses, error pulses and miso bits.
`default_nettype none

module tb_spi_reg_bridge;

  localparam int HALF = 50;

  logic        clk;
  logic        xrst;
  logic        sck;
  logic        ssn;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic        cs;
  logic        rw;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        frm_err;

  int vectors;
  int miscompares;
  int exp_err;
  int obs_err;

  typedef struct {
    logic        rw;
    logic [7:0]  a;
    logic [31:0] d;
  } acc_t;

  acc_t exp_q[$];

  function automatic logic [31:0] rd_model(input logic [7:0] a);
    if (a == 8'h10) return 32'h1234_5678;
    return {a, ~a, a ^ 8'h5A, 8'hA5};
  endfunction

  assign rdata = rd_model(addr);

  spi_reg_bridge #(.SYNC_STAGES(2), .DATA_W(32)) dut (
    .clk(clk), .xrst(xrst), .sck(sck), .ssn(ssn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cs(cs), .rw(rw), .addr(addr),
    .wdata(wdata), .rdata(rdata), .frm_err(frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor: every cs pulse must match the next predicted access.
  always @(negedge clk) begin
    acc_t e;
    if (frm_err) obs_err++;
    if (cs) begin
      if (!xrst) chk("cs_in_reset", 32'(cs), 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL cs_unexpected: got cs=1 rw=%0b addr=%h expected no access", rw, addr);
      end else begin
        e = exp_q.pop_front();
        chk("bus_rw", 32'(rw), 32'(e.rw));
        chk("bus_addr", 32'(addr), 32'(e.a));
        if (e.rw) chk("bus_wdata", wdata, e.d);
      end
    end
  end

  task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                       input int nbits, output logic [31:0] got);
    logic [47:0] bits;
    logic [31:0] rv;
    logic        exp_m;
    bits = {c, a, d};
    rv   = rd_model(a);
    got  = '0;
    if (c == 8'h02) begin
      if (nbits >= 48) exp_q.push_back('{1'b1, a, d});
      else exp_err++;
    end else if (c == 8'h03) begin
      if (nbits >= 16) exp_q.push_back('{1'b0, a, 32'h0});
      if (nbits < 48) exp_err++;
    end else begin
      exp_err++;
    end
    ssn = 1'b0;
    #40;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 48) ? bits[47-i] : 1'b0;
      #HALF;
      if (i == 0) chk("miso_oe", 32'(miso_oe), 32'd1);
      exp_m = (c == 8'h03 && i >= 16 && i < 48) ? rv[47-i] : 1'b0;
      chk("miso_bit", 32'(miso), 32'(exp_m));
      if (i >= 16 && i < 48) got[47-i] = miso;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
    #HALF;
    ssn  = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
    chk("miso_oe_idle", 32'(miso_oe), 32'd0);
    chk("frm_err_count", 32'(obs_err), 32'(exp_err));
    chk("cs_pending", 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] got;
  logic [47:0] pbits;

  initial begin
    vectors = 0; miscompares = 0; exp_err = 0; obs_err = 0;
    xrst = 1'b0; sck = 1'b0; ssn = 1'b1; mosi = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_rw", 32'(rw), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_frm_err", 32'(frm_err), 32'd0);
    xrst = 1'b1;
    repeat (10) @(negedge clk);

    frame(8'h02, 8'h03, 32'h0000_ABCD, 48, got);
    chk("wr_addr", 32'(addr), 32'h03);
    chk("wr_wdata", wdata, 32'h0000_ABCD);
    chk("wr_no_err", 32'(obs_err), 32'd0);

    frame(8'h03, 8'h10, 32'h0, 48, got);
    chk("rd_word", got, 32'h1234_5678);
    chk("rd_addr", 32'(addr), 32'h10);

    frame(8'h05, 8'h00, 32'hFFFF_FFFF, 48, got);
    chk("bad_err_total", 32'(obs_err), 32'd1);

    frame(8'h02, 8'h00, 32'h1357_9BDF, 30, got);
    chk("abort_wdata_kept", wdata, 32'h0000_ABCD);
    chk("abort_err_total", 32'(obs_err), 32'd2);

    frame(8'h03, 8'h20, 32'h0, 56, got);
    chk("long_rd_word", got, 32'h20DF_7AA5);
    frame(8'h02, 8'h04, 32'h0000_BEEF, 48, got);
    chk("b2b_addr", 32'(addr), 32'h04);
    chk("b2b_wdata", wdata, 32'h0000_BEEF);

    // Reset in the middle of a write frame, select held low across release.
    pbits = {8'h02, 8'h00, 32'h5555_AAAA};
    ssn = 1'b0;
    #40;
    for (int i = 0; i < 20; i++) begin
      mosi = pbits[47-i];
      #HALF;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
    xrst = 1'b0;
    #2;
    chk("mrst_cs", 32'(cs), 32'd0);
    chk("mrst_rw", 32'(rw), 32'd0);
    chk("mrst_addr", 32'(addr), 32'd0);
    chk("mrst_wdata", wdata, 32'd0);
    chk("mrst_miso", 32'(miso), 32'd0);
    chk("mrst_miso_oe", 32'(miso_oe), 32'd0);
    chk("mrst_frm_err", 32'(frm_err), 32'd0);
    #8;
    repeat (5) @(negedge clk);
    xrst = 1'b1;
    repeat (10) @(negedge clk);
    ssn  = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
    chk("mrst_err_total", 32'(obs_err), 32'(exp_err));
    chk("mrst_no_cs", 32'(exp_q.size()), 32'd0);

    frame(8'h03, 8'h10, 32'h0, 48, got);
    chk("post_rst_rd_word", got, 32'h1234_5678);
    chk("post_rst_addr", 32'(addr), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
